// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line-refill path.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REQ    = 2'd2,
    STROBE = 2'd3
  } fetch_state_e;

  localparam int H_VISIBLE    = 640;
  localparam int SPRITE_WORDS = 2;

  localparam logic [1:0] DS_WORD0 = 2'b01;
  localparam logic [1:0] DS_WORD1 = 2'b10;

endpackage

// File: rtl/sprite_fetch_ctrl.sv
// Per-line sprite graphics refill sequencer. Walks priority slots during
// HBLANK, reads two graphics words per slot over a req/ack port and hands
// each word to the addressed icon with a one-hot strobe.
// Optional: define SPRITE_FETCH_STATS_EN to add a saturating overrun counter
// (overrun_count) with a synchronous clear input (stats_clr).
module sprite_fetch_ctrl
  import sprite_pkg::*;
#(
  parameter int SLOTS     = 16,
  parameter int START_COL = H_VISIBLE + 8,
  parameter int ABORT_COL = 792,
  parameter int ADDR_WAIT = 2,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pix_row,
  input  logic [11:0] pix_col,
  output logic [3:0]  sprite_index,
  input  logic [11:0] sprite_addr,
  output logic [1:0]  sprite_graphics_data_valid,
  output logic [31:0] sprite_graphics_di,
  output logic        mem_req,
  output logic [12:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
`ifdef SPRITE_FETCH_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] overrun_count,
`endif
  output logic        overrun
);

  fetch_state_e state_q, state_d;
  logic [3:0]   slot_q, slot_d;
  logic         word_sel_q, word_sel_d;
  logic [3:0]   wait_q, wait_d;
  logic [11:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic         abort_q, abort_d;
  logic         done_q, done_d;

  logic row_ok, launch, abort_now, last_word, last_slot;

  // The launch line is the one before the next visible row (incl. wrap from the last row).
  assign row_ok    = (pix_row < 12'(V_ACTIVE - 1)) || (pix_row == 12'(V_TOTAL - 1));
  assign launch    = (state_q == IDLE) && (pix_col == 12'(START_COL)) && row_ok;
  assign abort_now = (state_q != IDLE) && (pix_col == 12'(ABORT_COL));
  assign last_word = (word_sel_q == 1'(SPRITE_WORDS - 1));
  assign last_slot = (slot_q == 4'(SLOTS - 1));

  // All outputs decode straight from state flops; mem_req therefore drops with reset.
  // overrun is raised in the deadline cycle itself so the arbiter sees it at ABORT_COL.
  assign sprite_index               = slot_q;
  assign mem_req                    = (state_q == REQ);
  assign mem_addr                   = {addr_q, word_sel_q};
  assign sprite_graphics_data_valid = (state_q == STROBE) ? (word_sel_q ? DS_WORD1 : DS_WORD0) : 2'b00;
  assign sprite_graphics_di         = data_q;
  assign busy                       = (state_q != IDLE);
  assign done                       = done_q;
  assign overrun                    = abort_now;

  // Next-state logic for the slot/word walk, including deadline abort handling.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    word_sel_d = word_sel_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    data_d     = data_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          slot_d  = '0;
          wait_d  = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort_now) begin
          state_d = IDLE;
        end else if (wait_q == 4'(ADDR_WAIT - 1)) begin
          addr_d     = sprite_addr;
          word_sel_d = 1'b0;
          state_d    = REQ;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      REQ: begin
        // A request is never withdrawn; an abort only marks the data for discard.
        if (abort_now) abort_d = 1'b1;
        if (mem_ack) begin
          if (abort_now || abort_q) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            data_d  = mem_rdata;
            state_d = STROBE;
          end
        end
      end
      STROBE: begin
        if (abort_now) begin
          state_d = IDLE;
        end else if (!last_word) begin
          word_sel_d = 1'b1;
          state_d    = REQ;
        end else if (last_slot) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          slot_d  = slot_q + 4'd1;
          wait_d  = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      word_sel_q <= 1'b0;
      wait_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      word_sel_q <= word_sel_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
    end
  end

`ifdef SPRITE_FETCH_STATS_EN
  logic [15:0] overrun_count_q, overrun_count_d;

  // Saturating overrun counter; clear wins over a coincident increment.
  always_comb begin
    overrun_count_d = overrun_count_q;
    if (stats_clr)
      overrun_count_d = '0;
    else if (overrun && (overrun_count_q != 16'hFFFF))
      overrun_count_d = overrun_count_q + 16'd1;
  end

  // Overrun counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_count_q <= '0;
    else        overrun_count_q <= overrun_count_d;
  end

  assign overrun_count = overrun_count_q;
`endif

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Self-checking bench for sprite_fetch_ctrl: table of line scenarios with
// hand-derived expectations, randomized lines against a timeline model,
// plus reset-mid-fetch and (when enabled) overrun statistics sequences.
module tb_sprite_fetch_ctrl;

  localparam int SLOTS = 16;
  localparam int AW    = 2;
  localparam int LAUNCH_COL = 648;
  localparam int ABORT = 792;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pix_row, pix_col, sprite_addr;
  logic [3:0]  sprite_index;
  logic [1:0]  ds;
  logic [31:0] di;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy, done, overrun;
  logic        stats_clr;
`ifdef SPRITE_FETCH_STATS_EN
  logic [15:0] overrun_count;
`endif

  always #5 clk = ~clk;

  sprite_fetch_ctrl dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .pix_row                    (pix_row),
    .pix_col                    (pix_col),
    .sprite_index               (sprite_index),
    .sprite_addr                (sprite_addr),
    .sprite_graphics_data_valid (ds),
    .sprite_graphics_di         (di),
    .mem_req                    (mem_req),
    .mem_addr                   (mem_addr),
    .mem_ack                    (mem_ack),
    .mem_rdata                  (mem_rdata),
    .busy                       (busy),
    .done                       (done),
`ifdef SPRITE_FETCH_STATS_EN
    .stats_clr                  (stats_clr),
    .overrun_count              (overrun_count),
`endif
    .overrun                    (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Memory contents and ack behaviour for one line.
  logic [11:0] addr_tab [SLOTS];
  logic [31:0] data_tab [SLOTS][2];
  int          lat      [SLOTS][2];
  int          hk, hw, hack, clr_col;

  typedef struct {
    int          col;
    int          idx;
    int          ds;
    logic [31:0] data;
  } strobe_t;

  strobe_t exp_s[$], obs_s[$];
  int      exp_req[$], obs_req[$];
  int      e_done, e_ovr, e_rise, e_fall;
  int      o_done, o_ovr, o_rise, o_fall, o_ndone, o_novr;

  // Timeline model: walk slot/word phases in column time, stop at the deadline.
  function automatic void model(input int row);
    int t, ack, s;
    exp_s.delete(); exp_req.delete();
    e_done = -1; e_ovr = -1; e_rise = -1; e_fall = -1;
    if (!(row < 479 || row == 524)) return;
    t = LAUNCH_COL + 1;
    e_rise = t;
    for (int k = 0; k < SLOTS; k++) begin
      if (ABORT >= t && ABORT <= t + AW - 1) begin
        e_ovr = ABORT; e_fall = ABORT + 1; return;
      end
      t += AW;
      for (int w = 0; w < 2; w++) begin
        ack = (k == hk && w == hw) ? hack : t + lat[k][w] - 1;
        exp_req.push_back((int'(addr_tab[k]) << 1) | w);
        if (ABORT >= t && ABORT <= ack) begin
          e_ovr = ABORT; e_fall = ack + 1; return;
        end
        s = ack + 1;
        exp_s.push_back('{s, k, (w != 0) ? 2 : 1, data_tab[k][w]});
        if (s == ABORT) begin
          e_ovr = ABORT; e_fall = ABORT + 1; return;
        end
        t = s + 1;
      end
    end
    e_done = t;
    e_fall = t;
  endfunction

  // Drive one line (cols 640..815), acting as the sprite manager and memory.
  task automatic run_line(input int row, input int rst_slot, output bit hit_rst);
    bit          req_prev = 1'b0;
    int          req_cnt  = 0;
    int          unstable = 0;
    logic [12:0] cur_addr = '0;
    obs_s.delete(); obs_req.delete();
    o_done = -1; o_ovr = -1; o_rise = -1; o_fall = -1; o_ndone = 0; o_novr = 0;
    hit_rst = 1'b0;
    for (int col = 640; col <= 815; col++) begin
      @(posedge clk); #1;
      pix_row     = 12'(row);
      pix_col     = 12'(col);
      stats_clr   = (col == clr_col);
      sprite_addr = addr_tab[sprite_index];
      mem_ack     = 1'b0;
      mem_rdata   = $urandom;
      if (mem_req) begin
        if (rst_slot >= 0 && int'(sprite_index) == rst_slot) begin
          rst_n = 1'b0;
          #1;
          check("async_reset_outputs",
                {9'd0, sprite_index, ds, di, mem_req, mem_addr, busy, done, overrun}, 64'sd0);
          hit_rst = 1'b1;
          @(negedge clk); @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (!req_prev) begin
          cur_addr = mem_addr;
          obs_req.push_back(int'(mem_addr));
          req_cnt = 0;
        end else if (mem_addr !== cur_addr) begin
          unstable++;
        end
        req_cnt++;
        if (int'(sprite_index) == hk && int'(mem_addr[0]) == hw)
          mem_ack = (col == hack);
        else
          mem_ack = (req_cnt == lat[sprite_index][mem_addr[0]]);
        if (mem_ack) mem_rdata = data_tab[sprite_index][mem_addr[0]];
      end
      req_prev = mem_req;
      @(negedge clk);
      if (ds != 2'b00) obs_s.push_back('{col, int'(sprite_index), int'(ds), di});
      if (done)    begin o_ndone++; if (o_done < 0) o_done = col; end
      if (overrun) begin o_novr++;  if (o_ovr  < 0) o_ovr  = col; end
      if (busy && o_rise < 0) o_rise = col;
      if (!busy && o_rise >= 0 && o_fall < 0) o_fall = col;
    end
    mem_ack   = 1'b0;
    stats_clr = 1'b0;
    check("req_addr_stable", unstable, 0);
  endtask

  task automatic compare_line(input string tag);
    check({tag, " strobe_count"}, obs_s.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      check({tag, " strobe_col"},  obs_s[i].col, exp_s[i].col);
      check({tag, " strobe_idx"},  obs_s[i].idx, exp_s[i].idx);
      check({tag, " strobe_ds"},   obs_s[i].ds,  exp_s[i].ds);
      check({tag, " strobe_data"}, obs_s[i].data, exp_s[i].data);
    end
    check({tag, " req_count"}, obs_req.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < obs_req.size(); i++)
      check({tag, " mem_addr"}, obs_req[i], exp_req[i]);
    check({tag, " done_col"},     o_done, e_done);
    check({tag, " done_pulses"},  o_ndone, (e_done >= 0) ? 1 : 0);
    check({tag, " overrun_col"},  o_ovr, e_ovr);
    check({tag, " overrun_pulses"}, o_novr, (e_ovr >= 0) ? 1 : 0);
    check({tag, " busy_rise"},    o_rise, e_rise);
    check({tag, " busy_fall"},    o_fall, e_fall);
  endtask

  task automatic fill_line(input int fixed_lat);
    for (int k = 0; k < SLOTS; k++) begin
      addr_tab[k] = 12'($urandom);
      for (int w = 0; w < 2; w++) begin
        data_tab[k][w] = $urandom;
        lat[k][w] = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      end
    end
  endtask

  typedef struct {
    int row; int lat; int hk; int hw; int hack;
    int n_strobe; int done_col; int ovr_col; int fall_col;
  } vec_t;

  vec_t tbl[8];
  bit   hit;

  initial begin
    tbl[0] = '{10,  1, -1, 0, 0,   32, 745, -1,  745};
    tbl[1] = '{10,  3, -1, 0, 0,   28, -1,  792, 794};
    tbl[2] = '{479, 1, -1, 0, 0,   0,  -1,  -1,  -1};
    tbl[3] = '{524, 1, -1, 0, 0,   32, 745, -1,  745};
    tbl[4] = '{478, 1, -1, 0, 0,   32, 745, -1,  745};
    tbl[5] = '{10,  1,  9, 1, 800, 19, -1,  792, 801};
    tbl[6] = '{480, 1, -1, 0, 0,   0,  -1,  -1,  -1};
    tbl[7] = '{0,   2, -1, 0, 0,   32, 777, -1,  777};

    rst_n = 1'b0; pix_row = '0; pix_col = '0; sprite_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0; stats_clr = 1'b0;
    hk = -1; hw = 0; hack = 0; clr_col = -1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {9'd0, sprite_index, ds, di, mem_req, mem_addr, busy, done, overrun}, 64'sd0);
`ifdef SPRITE_FETCH_STATS_EN
    check("reset_overrun_count", overrun_count, 0);
`endif
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      fill_line(tbl[i].lat);
      hk = tbl[i].hk; hw = tbl[i].hw; hack = tbl[i].hack;
      model(tbl[i].row);
      run_line(tbl[i].row, -1, hit);
      check($sformatf("tbl%0d n_strobe", i), obs_s.size(), tbl[i].n_strobe);
      check($sformatf("tbl%0d done_col", i), o_done, tbl[i].done_col);
      check($sformatf("tbl%0d ovr_col", i),  o_ovr,  tbl[i].ovr_col);
      check($sformatf("tbl%0d fall_col", i), o_fall, tbl[i].fall_col);
      compare_line($sformatf("tbl%0d", i));
    end

    // Randomized lines: mixed ack latencies, rows and occasional held acks.
    for (int n = 0; n < 10; n++) begin
      int row;
      int rows[6] = '{5, 100, 478, 524, 479, 300};
      row = rows[$urandom_range(0, 5)];
      fill_line(0);
      if ($urandom_range(0, 3) == 0) begin
        hk = int'($urandom_range(0, 10)); hw = int'($urandom_range(0, 1)); hack = 795 + int'($urandom_range(0, 10));
      end else begin
        hk = -1;
      end
      model(row);
      run_line(row, -1, hit);
      compare_line($sformatf("rand%0d", n));
    end
    hk = -1;

    // Reset during slot 5 request, then a clean fetch on the next qualifying line.
    fill_line(1);
    run_line(10, 5, hit);
    check("reset_reached_slot5", hit, 1);
    fill_line(1);
    model(11);
    run_line(11, -1, hit);
    compare_line("post_reset");

`ifdef SPRITE_FETCH_STATS_EN
    hk = 0; hw = 0; hack = 800;
    for (int n = 0; n < 3; n++) begin
      fill_line(1);
      run_line(10, -1, hit);
    end
    check("overrun_count_3", overrun_count, 3);
    clr_col = 792;
    fill_line(1);
    run_line(10, -1, hit);
    check("overrun_count_clr", overrun_count, 0);
    check("overrun_with_clr", o_ovr, 792);
    clr_col = -1; hk = -1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
